// File: rtl/accumulator_stage_if.sv
// Request/result bundle between the upstream requester and accumulator_stage.
// The master drives requests; the slave (the stage) returns handshake and result state.
interface accumulator_stage_if #(
  parameter int WIDTH = 4
) ();
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] acc_out;
  logic             carry;
  logic             zero;
  logic             done;
  logic             busy;

  modport master (
    output in_valid,
    output op,
    output operand,
    input  in_ready,
    input  acc_out,
    input  carry,
    input  zero,
    input  done,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  op,
    input  operand,
    output in_ready,
    output acc_out,
    output carry,
    output zero,
    output done,
    output busy
  );
endinterface

// File: rtl/accumulator_stage.sv
// Accumulator stage behind the combinational WIDTH-bit adder: single-cycle LOAD/ADD/ADC/CLR
// plus a WIDTH-cycle shift-and-add multiply that reuses the same adder every cycle.
module accumulator_stage #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  accumulator_stage_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};

  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_ADC  = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_CLR  = 3'b101;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] acc_r, acc_s;
  logic             carry_r, carry_s;
  logic             zero_r, zero_s;
  logic             done_r, done_s;
  logic             busy_r, busy_s;
  logic [WIDTH-1:0] m_r, m_s;
  logic [WIDTH-1:0] h_r, h_s;
  logic [WIDTH-1:0] l_r, l_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;

  logic [WIDTH-1:0] add_a_s;
  logic [WIDTH-1:0] add_b_s;
  logic             add_cin_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   hn_s;
  logic [WIDTH-1:0] mul_h_next_s;
  logic [WIDTH-1:0] mul_l_next_s;
  logic             transfer_s;

  function automatic logic [WIDTH:0] comb_adder(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic             cin
  );
    comb_adder = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  endfunction

  assign transfer_s   = bus.in_valid && (state_r == ST_IDLE);
  assign bus.in_ready = (state_r == ST_IDLE);
  assign bus.acc_out  = acc_r;
  assign bus.carry    = carry_r;
  assign bus.zero     = zero_r;
  assign bus.done     = done_r;
  assign bus.busy     = busy_r;

  // Adder operand select: partial product H + M while multiplying, else ACC + OPERAND (+CARRY on ADC)
  always_comb begin
    add_a_s   = acc_r;
    add_b_s   = bus.operand;
    add_cin_s = 1'b0;
    if (state_r == ST_MUL) begin
      add_a_s = h_r;
      add_b_s = m_r;
    end else if (bus.op == OP_ADC) begin
      add_cin_s = carry_r;
    end else begin
      add_cin_s = 1'b0;
    end
  end

  assign sum_s = comb_adder(add_a_s, add_b_s, add_cin_s);

  // One shift-and-add step: conditionally add M into H, then shift {c,H,L} right by one
  always_comb begin
    hn_s         = l_r[0] ? sum_s : {1'b0, h_r};
    mul_h_next_s = hn_s[WIDTH:1];
    mul_l_next_s = {hn_s[0], l_r[WIDTH-1:1]};
  end

  // Next-state and next-register values for the IDLE/MUL controller
  always_comb begin
    state_s = state_r;
    acc_s   = acc_r;
    carry_s = carry_r;
    zero_s  = zero_r;
    done_s  = 1'b0;
    busy_s  = busy_r;
    m_s     = m_r;
    h_s     = h_r;
    l_s     = l_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        busy_s = 1'b0;
        if (transfer_s) begin
          case (bus.op)
            OP_LOAD: begin
              acc_s  = bus.operand;
              zero_s = (bus.operand == ZERO_W);
              done_s = 1'b1;
            end
            OP_ADD, OP_ADC: begin
              acc_s   = sum_s[WIDTH-1:0];
              carry_s = sum_s[WIDTH];
              zero_s  = (sum_s[WIDTH-1:0] == ZERO_W);
              done_s  = 1'b1;
            end
            OP_MUL: begin
              m_s     = bus.operand;
              l_s     = acc_r;
              h_s     = ZERO_W;
              cnt_s   = CNT_ZERO;
              state_s = ST_MUL;
              busy_s  = 1'b1;
            end
            OP_CLR: begin
              acc_s   = ZERO_W;
              carry_s = 1'b0;
              zero_s  = 1'b1;
              done_s  = 1'b1;
            end
            default: begin
              // NOP and the reserved codes complete without touching state
              done_s = 1'b1;
            end
          endcase
        end else begin
          done_s = 1'b0;
        end
      end
      ST_MUL: begin
        h_s   = mul_h_next_s;
        l_s   = mul_l_next_s;
        cnt_s = cnt_r + CNT_ONE;
        if (cnt_r == CNT_LAST) begin
          acc_s   = mul_l_next_s;
          carry_s = |mul_h_next_s;
          zero_s  = (mul_l_next_s == ZERO_W);
          state_s = ST_IDLE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
        end else begin
          state_s = ST_MUL;
          busy_s  = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset discards any multiply in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      acc_r   <= ZERO_W;
      carry_r <= 1'b0;
      zero_r  <= 1'b1;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
      m_r     <= ZERO_W;
      h_r     <= ZERO_W;
      l_r     <= ZERO_W;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_s;
      acc_r   <= acc_s;
      carry_r <= carry_s;
      zero_r  <= zero_s;
      done_r  <= done_s;
      busy_r  <= busy_s;
      m_r     <= m_s;
      h_r     <= h_s;
      l_r     <= l_s;
      cnt_r   <= cnt_s;
    end
  end

endmodule

// File: doc/accumulator_stage.md
Name: accumulator_stage

Overview:
- Sequential stage directly downstream of the CombAdder_4bit datapath in ALU.v.
- Accepts operation requests over a valid/ready handshake and feeds the accumulator and an operand into the adder.
- Registers the adder's {OVERFLOW,OUT} result into a 4-bit accumulator with CARRY and ZERO flags.
- Also runs a multi-cycle shift-and-add multiply that reuses the same adder once per cycle.

Parameters:
- WIDTH, 4, accumulator/operand width; matches the adder width. MUL latency is WIDTH cycles.

Ports:
- CLK  input  1  rising-edge clock
- RESET  input  1  asynchronous, active-high reset
- IN_VALID  input  1  request present on OP/OPERAND
- IN_READY  output  1  stage can accept a request this cycle
- OP  input  3  000 NOP, 001 LOAD, 010 ADD, 011 ADC, 100 MUL, 101 CLR, 110/111 treated as NOP
- OPERAND  input  WIDTH  second operand
- ACC_OUT  output  WIDTH  accumulator register
- CARRY  output  1  carry / multiply-overflow flag
- ZERO  output  1  ACC_OUT == 0 flag
- DONE  output  1  one-cycle pulse: the previous edge completed an operation
- BUSY  output  1  multiply in progress

Behaviour:
- Clocking: one clock, CLK. RESET is asynchronous, active-high.
- RESET (async, any state, including mid-MUL):
  - ACC_OUT=0, CARRY=0, ZERO=1, DONE=0, BUSY=0, state=IDLE.
  - Any in-flight MUL is discarded.
- Handshake:
  - A transfer occurs on a rising CLK edge with IN_VALID && IN_READY.
  - IN_READY = (state==IDLE), combinational from state only, never from IN_VALID.
  - OP/OPERAND are sampled only at the transfer edge.
- States: IDLE, MUL.
- IDLE, single-cycle ops, applied at the transfer edge:
  - LOAD: ACC<=OPERAND; CARRY unchanged.
  - ADD: {CARRY,ACC}<=ACC+OPERAND, as a 5-bit adder result.
  - ADC: {CARRY,ACC}<=ACC+OPERAND+CARRY (old CARRY). Implemented as two passes through the adder or an equivalent 5-bit sum; the result must equal the 5-bit true sum truncated to the carry bit.
  - CLR: ACC<=0, CARRY<=0.
  - NOP and 110/111: no register change.
  - ZERO<=(new ACC==0) for every op; ZERO is unchanged on NOP.
  - DONE<=1 on the edge after... specifically, DONE is registered: high for exactly the one cycle following the transfer edge.
  - Throughput is one op per cycle; back-to-back transfers give continuous DONE.
- IDLE, MUL: at the transfer edge:
  - Latch M<=OPERAND, L<=ACC, H<=0, cnt<=0.
  - State<=MUL, BUSY<=1. DONE stays 0.
- MUL state, each edge (iteration):
  - {c,Hn} = L[0] ? H+M : {0,H}.
  - {H,L} <= {c,Hn,L}>>1.
  - cnt<=cnt+1.
- MUL completion, on the edge where cnt==WIDTH-1:
  - ACC<=final L, i.e. the low nibble of the 8-bit product.
  - CARRY<=|(final H), i.e. the product overflowed 4 bits.
  - ZERO<=(final L==0).
  - State<=IDLE, BUSY<=0, DONE<=1 for the next cycle.
- MUL latency:
  - IN_READY is low for WIDTH cycles after the transfer.
  - DONE is high in cycle WIDTH+1, counting the transfer edge as edge 0.
  - During MUL, IN_VALID is ignored; requests stall upstream.
- ACC_OUT, CARRY and ZERO are stable (old values) throughout MUL until the completion edge.
- Wrap-around:
  - ADD/ADC results are modulo 16, with carry out in CARRY.
  - The MUL product is modulo 16, with overflow in CARRY.
- Simultaneous events: RESET asserted on the same edge as a transfer wins; the request is lost and IN_READY stays high.

Test Plan:
- Reset: assert RESET mid-cycle without a clock edge -> ACC_OUT=0, CARRY=0, ZERO=1, DONE=0, IN_READY=1 immediately.
- Exhaustive ADD: for all a,b in 0..15, LOAD a, then ADD b -> {CARRY,ACC_OUT}=a+b, ZERO==(ACC_OUT==0), DONE pulses once per op.
- ADC chain:
  - LOAD 15, ADD 1 -> ACC=0, CARRY=1, ZERO=1.
  - Then ADC 0 -> ACC=1, CARRY=0, ZERO=0.
  - Then CLR -> ACC=0, CARRY=0, ZERO=1.
- MUL:
  - LOAD 3, MUL 5 -> IN_READY low 4 cycles, BUSY high 4 cycles, DONE one cycle later, ACC=15, CARRY=0.
  - LOAD 7, MUL 9 (product 63) -> ACC=15, CARRY=1.
  - Exhaustive 16x16 check: ACC==(a*b)%16, CARRY==(a*b>15).
- Stall/back-to-back:
  - Hold IN_VALID high with ADD 1 continuously from ACC=14 -> ACC 15,0,1 on successive cycles, CARRY=1 only after the 15->0 step, DONE continuous.
  - MUL inserted mid-stream -> the following ADD is accepted only when IN_READY returns high.
- Reset mid-MUL: LOAD 7, MUL 9, assert RESET after 2 cycles -> ACC=0, BUSY=0, no DONE pulse. The next LOAD 2 completes normally.
